// File: rtl/life_pkg.sv
// Shared constants and types for the game-of-life cell datapath.
// Imported by the 8-to-3 scanner, its bus interface and the priority encoder.
package life_pkg;

    localparam int CELLS = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/encoder_8_to_3_scanner_if.sv
// Request/index bus of the 8-to-3 scanner: the vector load side and the index emit side.
// The slave modport is the scanner's view, and the master modport is the view of its neighbours.
interface encoder_8_to_3_scanner_if;
    import life_pkg::*;

    logic             in_valid;
    logic [CELLS-1:0] in;
    logic             in_ready;
    logic [IDX_W-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [3:0]       count;

    modport slave (
        input  in_valid,
        input  in,
        output in_ready,
        output out,
        output out_valid,
        input  out_ready,
        output out_last,
        output count
    );

    modport master (
        output in_valid,
        output in,
        input  in_ready,
        input  out,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  count
    );

endinterface

// File: rtl/priority_encoder_8_to_3.sv
// Combinational priority encoder: returns the index of the first set bit of vec,
// along with flags that report whether any bit is set and whether exactly one bit is set.
module priority_encoder_8_to_3
    import life_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [CELLS-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             onehot
);

    // NOTE: idx gets a default before the loops so that every path assigns it and no latch is inferred.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < CELLS; i++)
                if (vec[i]) idx = IDX_W'(i);
        end else begin
            for (int i = CELLS - 1; i >= 0; i--)
                if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign any = |vec;
    // Clearing the lowest set bit leaves zero only when a single bit was set.
    assign onehot = any && ((vec & (vec - CELLS'(1))) == '0);

endmodule

// File: rtl/encoder_8_to_3_scanner.sv
// Sequential 8-to-3 encoder: loads an 8-bit request vector, then emits the index of each set bit
// in turn, one per handshake, in a fixed priority order.
module encoder_8_to_3_scanner
    import life_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    encoder_8_to_3_scanner_if.slave  bus
);

    scan_state_t      state;
    logic [CELLS-1:0] pending;
    logic [3:0]       count_q;

    logic [IDX_W-1:0] idx;
    logic             any;
    logic             onehot;
    logic             accept;
    logic [CELLS-1:0] pending_cleared;

    priority_encoder_8_to_3 #(.MSB_FIRST(MSB_FIRST)) u_prio (
        .vec    (pending),
        .idx    (idx),
        .any    (any),
        .onehot (onehot)
    );

    assign bus.in_ready  = ena && (state == IDLE);
    assign bus.out_valid = ena && (state == SCAN);
    assign bus.out       = (state == SCAN && any) ? idx : '0;
    assign bus.out_last  = bus.out_valid && onehot;
    assign bus.count     = count_q;

    assign accept          = bus.out_valid && bus.out_ready;
    assign pending_cleared = pending & ~(CELLS'(1) << idx);

    // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            count_q <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        pending <= bus.in;
                        count_q <= '0;
                        if (bus.in != '0) state <= SCAN;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        pending <= pending_cleared;
                        count_q <= count_q + 4'd1;
                        if (onehot) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
